// File: rtl/mips32_mem_bridge_pkg.sv
// Shared constants for the MIPS32 data-memory bridge: FSM encoding, lane count
// and data width.
package mips32_mem_pkg;

  localparam int MEM_DWIDTH = 32;
  localparam int LANES      = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RWAIT = 2'd1;
  localparam logic [1:0] ST_RDONE = 2'd2;
  localparam logic [1:0] ST_WDONE = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    RWAIT = ST_RWAIT,
    RDONE = ST_RDONE,
    WDONE = ST_WDONE
  } bridge_state_t;

endpackage

// File: rtl/mips32_mem_bridge_if.sv
// Core-side data-memory bus: request/address/data from the core, read data,
// acknowledge and sticky error flag back from the bridge.
interface mips32_mem_bridge_if;
  import mips32_mem_pkg::*;

  logic                  DataMem_Read;
  logic [LANES-1:0]      DataMem_Write;
  logic [29:0]           DataMem_Address;
  logic [MEM_DWIDTH-1:0] DataMem_Out;
  logic [MEM_DWIDTH-1:0] DataMem_In;
  logic                  DataMem_Ready;
  logic                  BusError;
  logic                  ErrorClear;

  modport master (
    output DataMem_Read, DataMem_Write, DataMem_Address, DataMem_Out, ErrorClear,
    input  DataMem_In, DataMem_Ready, BusError
  );

  modport slave (
    input  DataMem_Read, DataMem_Write, DataMem_Address, DataMem_Out, ErrorClear,
    output DataMem_In, DataMem_Ready, BusError
  );

endinterface

// File: rtl/mips32_mem_bridge.sv
// Bridge between the core data-memory bus and a block RAM with a registered
// read address; absorbs the one-cycle read latency and flags out-of-range accesses.
module mips32_mem_bridge
  import mips32_mem_pkg::*;
#(
  parameter int AWIDTH = 10
) (
  input  logic                  clock,
  input  logic                  reset,
  mips32_mem_bridge_if.slave    bus,
  output logic [AWIDTH-1:0]     ramReadAddr,
  input  logic [MEM_DWIDTH-1:0] ramReadData,
  output logic [AWIDTH-1:0]     ramWriteAddr,
  output logic [MEM_DWIDTH-1:0] ramWriteData,
  output logic [LANES-1:0]      ramWriteLane,
  output logic                  ramWriteEnable
);

  bridge_state_t         state_q, state_d;
  logic [MEM_DWIDTH-1:0] data_in_q, data_in_d;
  logic                  ready_q, ready_d;
  logic                  bus_err_q, bus_err_d;
  logic                  oor_q, oor_d;

  logic                  in_range_s;
  logic                  wr_req_s;
  logic                  rd_req_s;
  logic                  wr_en_s;
  logic [LANES-1:0]      wr_lane_s;

  assign in_range_s = ((bus.DataMem_Address >> AWIDTH) == 30'd0);
  assign wr_req_s   = (bus.DataMem_Write != 4'b0000);
  assign rd_req_s   = bus.DataMem_Read;

  assign ramReadAddr  = bus.DataMem_Address[AWIDTH-1:0];
  assign ramWriteAddr = bus.DataMem_Address[AWIDTH-1:0];
  assign ramWriteData = bus.DataMem_Out;

  // The RAM write strobe must land in the accept cycle so it commits before Ready.
  assign ramWriteEnable = wr_en_s & ~reset;
  assign ramWriteLane   = reset ? 4'b0000 : wr_lane_s;

  assign bus.DataMem_In    = data_in_q;
  assign bus.DataMem_Ready = ready_q;
  assign bus.BusError      = bus_err_q;

  always_comb begin
    state_d   = state_q;
    data_in_d = data_in_q;
    ready_d   = 1'b0;
    oor_d     = oor_q;
    bus_err_d = bus_err_q & ~bus.ErrorClear;
    wr_en_s   = 1'b0;
    wr_lane_s = 4'b0000;

    case (state_q)
      IDLE: begin
        if (wr_req_s) begin
          if (in_range_s) begin
            wr_en_s   = 1'b1;
            wr_lane_s = bus.DataMem_Write;
          end else begin
            wr_en_s   = 1'b0;
          end
          // A simultaneous read is dropped and reported as a protocol error.
          if (!in_range_s || rd_req_s) begin
            bus_err_d = 1'b1;
          end else begin
            bus_err_d = bus_err_q & ~bus.ErrorClear;
          end
          state_d = WDONE;
          ready_d = 1'b1;
        end else if (rd_req_s) begin
          oor_d = ~in_range_s;
          if (!in_range_s) begin
            bus_err_d = 1'b1;
          end else begin
            bus_err_d = bus_err_q & ~bus.ErrorClear;
          end
          state_d = RWAIT;
        end else begin
          state_d = IDLE;
        end
      end
      RWAIT: begin
        data_in_d = oor_q ? 32'h0000_0000 : ramReadData;
        state_d   = RDONE;
        ready_d   = 1'b1;
      end
      RDONE: state_d = IDLE;
      WDONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      data_in_q <= 32'h0000_0000;
      ready_q   <= 1'b0;
      bus_err_q <= 1'b0;
      oor_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_in_q <= data_in_d;
      ready_q   <= ready_d;
      bus_err_q <= bus_err_d;
      oor_q     <= oor_d;
    end
  end

endmodule

// File: tb/tb_mips32_mem_bridge.sv
// Directed scoreboard bench for mips32_mem_bridge with a behavioural
// registered-address block RAM (LANES=4, DWIDTH=32).
module tb_mips32_mem_bridge;
  import mips32_mem_pkg::*;

  localparam int AWIDTH = 10;

  logic clock;
  logic reset;
  logic [AWIDTH-1:0] ramReadAddr;
  logic [31:0]       ramReadData;
  logic [AWIDTH-1:0] ramWriteAddr;
  logic [31:0]       ramWriteData;
  logic [3:0]        ramWriteLane;
  logic              ramWriteEnable;

  mips32_mem_bridge_if bus ();

  mips32_mem_bridge #(.AWIDTH(AWIDTH)) dut (
    .clock          (clock),
    .reset          (reset),
    .bus            (bus),
    .ramReadAddr    (ramReadAddr),
    .ramReadData    (ramReadData),
    .ramWriteAddr   (ramWriteAddr),
    .ramWriteData   (ramWriteData),
    .ramWriteLane   (ramWriteLane),
    .ramWriteEnable (ramWriteEnable)
  );

  logic [31:0]       mem [0:(1<<AWIDTH)-1];
  logic [AWIDTH-1:0] rd_addr_q;

  always @(posedge clock) begin
    if (ramWriteEnable) begin
      for (int i = 0; i < 4; i++) begin
        if (ramWriteLane[i]) mem[ramWriteAddr][i*8 +: 8] <= ramWriteData[i*8 +: 8];
      end
    end
    rd_addr_q <= ramReadAddr;
  end
  assign ramReadData = mem[rd_addr_q];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int          n_checks = 0;
  int          n_fails  = 0;
  logic [31:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(output int lat);
    lat = 0;
    do begin
      @(posedge clock); #1;
      lat++;
    end while (!bus.DataMem_Ready && lat < 8);
  endtask

  task automatic do_write(input logic [29:0] a, input logic [31:0] d, input logic [3:0] ln,
                          input logic rd, input logic exp_we);
    int lat;
    @(posedge clock); #1;
    bus.DataMem_Address = a;
    bus.DataMem_Out     = d;
    bus.DataMem_Write   = ln;
    bus.DataMem_Read    = rd;
    #1;
    check("idle_ready_low", {31'd0, bus.DataMem_Ready}, 32'd0);
    check("wr_enable", {31'd0, ramWriteEnable}, {31'd0, exp_we});
    wait_ready(lat);
    check("wr_latency", lat, 32'd1);
    bus.DataMem_Write = 4'b0000;
    bus.DataMem_Read  = 1'b0;
  endtask

  task automatic do_read(input logic [29:0] a, input logic [31:0] exp);
    int lat;
    exp_q.push_back(exp);
    @(posedge clock); #1;
    bus.DataMem_Address = a;
    bus.DataMem_Read    = 1'b1;
    bus.DataMem_Write   = 4'b0000;
    check("idle_ready_low", {31'd0, bus.DataMem_Ready}, 32'd0);
    wait_ready(lat);
    check("rd_latency", lat, 32'd2);
    if (bus.DataMem_Ready) check("rd_data", bus.DataMem_In, exp_q.pop_front());
    else void'(exp_q.pop_front());
    bus.DataMem_Read = 1'b0;
  endtask

  task automatic clear_err();
    @(posedge clock); #1;
    bus.ErrorClear = 1'b1;
    @(posedge clock); #1;
    bus.ErrorClear = 1'b0;
    check("err_cleared", {31'd0, bus.BusError}, 32'd0);
  endtask

  initial begin
    reset               = 1'b1;
    bus.DataMem_Read    = 1'b0;
    bus.DataMem_Write   = 4'b0000;
    bus.DataMem_Address = 30'd0;
    bus.DataMem_Out     = 32'h0;
    bus.ErrorClear      = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_ready", {31'd0, bus.DataMem_Ready}, 32'd0);
    check("rst_data_in", bus.DataMem_In, 32'h0);
    check("rst_buserr", {31'd0, bus.BusError}, 32'd0);
    check("rst_wr_en", {31'd0, ramWriteEnable}, 32'd0);
    check("rst_wr_lane", {28'd0, ramWriteLane}, 32'd0);
    reset = 1'b0;

    // Full-word write then read back.
    do_write(30'd5, 32'hDEADBEEF, 4'hF, 1'b0, 1'b1);
    do_read(30'd5, 32'hDEADBEEF);
    check("no_err_normal", {31'd0, bus.BusError}, 32'd0);

    // Single-lane partial write.
    do_write(30'd7, 32'h11223344, 4'hF, 1'b0, 1'b1);
    do_write(30'd7, 32'h000000AA, 4'b0001, 1'b0, 1'b1);
    do_read(30'd7, 32'h112233AA);

    // Read immediately after write to the same address.
    do_write(30'd9, 32'h0000_1111, 4'hF, 1'b0, 1'b1);
    do_read(30'd9, 32'h0000_1111);
    do_write(30'd9, 32'h9999_0009, 4'hF, 1'b0, 1'b1);
    do_read(30'd9, 32'h9999_0009);

    // Out-of-range read and write leave RAM word 0 intact.
    do_write(30'd0, 32'hCAFEF00D, 4'hF, 1'b0, 1'b1);
    do_read(30'd1024, 32'h0);
    check("oor_rd_err", {31'd0, bus.BusError}, 32'd1);
    clear_err();
    do_write(30'd1024, 32'h12345678, 4'hF, 1'b0, 1'b0);
    check("oor_wr_err", {31'd0, bus.BusError}, 32'd1);
    clear_err();
    do_read(30'd0, 32'hCAFEF00D);

    // Read and write together: write wins, error flagged.
    do_write(30'd3, 32'hA5A55A5A, 4'hF, 1'b1, 1'b1);
    check("rw_both_err", {31'd0, bus.BusError}, 32'd1);
    clear_err();
    do_read(30'd3, 32'hA5A55A5A);

    // Reset while waiting for read data aborts the access.
    @(posedge clock); #1;
    bus.DataMem_Address = 30'd5;
    bus.DataMem_Read    = 1'b1;
    @(posedge clock); #1;
    check("in_rwait", {30'd0, dut.state_q}, {30'd0, ST_RWAIT});
    reset            = 1'b1;
    bus.DataMem_Read = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    check("abort_state", {30'd0, dut.state_q}, {30'd0, ST_IDLE});
    check("abort_data_in", bus.DataMem_In, 32'h0);
    check("abort_ready", {31'd0, bus.DataMem_Ready}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clock); #1;
      check("abort_no_ready", {31'd0, bus.DataMem_Ready}, 32'd0);
    end
    do_read(30'd5, 32'hDEADBEEF);

    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
